tiny_host_port: RTL and testbench

- Host-side initiator for the `tiny` core's RAM access port (sel/addr/w/data/out).
- Takes 32-bit chunks from a narrow host stream and assembles one 1188-bit GF(3^M) element (M=593). Writes it into the core RAM.
- On a read command, fetches a RAM word and streams it back in 32-bit chunks.
- Sits between the host bus bridge and `tiny`, and replaces direct wide-bus access.

---
 rtl/tiny_host_pkg.sv | 12 +
 rtl/chunk_shift_reg.sv | 38 +++
 rtl/tiny_host_port.sv | 128 ++++++++++++
 tb/tb_tiny_host_port.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_host_pkg.sv
// Shared constants and FSM encoding for the host-side port of the tiny GF(3^M) core.
package tiny_host_pkg;
  localparam int M        = 593;
  localparam int WIDTH_D0 = 2 * M + 1;
  localparam int CW       = 32;
  localparam int NCHUNK   = (WIDTH_D0 + 1 + CW - 1) / CW;
  localparam int AW       = 6;
  localparam int RD_LAT   = 1;
  localparam int KW       = 6;

  typedef enum logic [2:0] {IDLE, LOAD, WR, RD_REQ, SEND} state_t;
endpackage

// File: rtl/chunk_shift_reg.sv
// Wide register with chunk-indexed parallel load, full-width capture and shift-right-by-CW.
module chunk_shift_reg #(
  parameter int W  = 1188,
  parameter int CW = 32,
  parameter int IW = 6,
  parameter int OW = W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [IW-1:0] idx,
  input  logic [CW-1:0] chunk,
  input  logic          capture,
  input  logic [W-1:0]  value,
  input  logic          shift,
  output logic [OW-1:0] q
);
  localparam int NCH = (W + CW - 1) / CW;

  logic [W-1:0] r;
  logic [W-1:0] loaded;

  // The final chunk is narrower than CW; its unused upper input bits are dropped.
  for (genvar c = 0; c < NCH; c++) begin : g_chunk
    localparam int LO = c * CW;
    localparam int HI = (LO + CW > W) ? W : LO + CW;
    assign loaded[HI-1:LO] = (idx == IW'(c)) ? chunk[HI-LO-1:0] : r[HI-1:LO];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r <= '0;
    else if (capture) r <= value;
    else if (load)    r <= loaded;
    else if (shift)   r <= r >> CW;
  end

  assign q = r[OW-1:0];
endmodule

// File: rtl/tiny_host_port.sv
// Host-side initiator for the tiny core RAM port: assembles/streams 1188-bit words as 32-bit chunks.
module tiny_host_port #(
  parameter int WIDTH_D0 = tiny_host_pkg::WIDTH_D0,
  parameter int CW       = tiny_host_pkg::CW,
  parameter int NCHUNK   = tiny_host_pkg::NCHUNK,
  parameter int AW       = tiny_host_pkg::AW,
  parameter int RD_LAT   = tiny_host_pkg::RD_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AW-1:0]       cmd_addr,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic [CW-1:0]       din,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [CW-1:0]       dout,
  output logic                sel,
  output logic [AW-1:0]       addr,
  output logic                w,
  output logic [WIDTH_D0:0]   data,
  input  logic [WIDTH_D0:0]   out,
  output logic                busy
);
  import tiny_host_pkg::*;

  localparam int LW = $clog2(RD_LAT + 1) + 1;

  state_t        state;
  logic [KW-1:0] k;
  logic [LW-1:0] lat;
  logic          din_hs;
  logic          dout_hs;
  logic          last;
  logic          capture;

  assign din_hs  = (state == LOAD) && din_valid && din_ready;
  assign dout_hs = (state == SEND) && dout_valid && dout_ready;
  assign last    = (k == KW'(NCHUNK - 1));
  assign capture = (state == RD_REQ) && (lat == LW'(RD_LAT));

  // Separate write and read registers so data stays put across read commands.
  chunk_shift_reg #(.W(WIDTH_D0 + 1), .CW(CW), .IW(KW), .OW(WIDTH_D0 + 1)) u_wr (
    .clk(clk), .reset(reset),
    .load(din_hs), .idx(k), .chunk(din),
    .capture(1'b0), .value('0), .shift(1'b0),
    .q(data)
  );

  chunk_shift_reg #(.W(WIDTH_D0 + 1), .CW(CW), .IW(KW), .OW(CW)) u_rd (
    .clk(clk), .reset(reset),
    .load(1'b0), .idx('0), .chunk('0),
    .capture(capture), .value(out), .shift(dout_hs),
    .q(dout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      k          <= '0;
      lat        <= '0;
      sel        <= 1'b0;
      w          <= 1'b0;
      addr       <= '0;
      dout_valid <= 1'b0;
      din_ready  <= 1'b0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          addr      <= cmd_addr;
          busy      <= 1'b1;
          cmd_ready <= 1'b0;
          k         <= '0;
          lat       <= '0;
          if (cmd_write) begin
            state     <= LOAD;
            din_ready <= 1'b1;
          end else begin
            state <= RD_REQ;
            sel   <= 1'b1;
          end
        end
        LOAD: if (din_hs) begin
          k <= k + KW'(1);
          if (last) begin
            state     <= WR;
            din_ready <= 1'b0;
            sel       <= 1'b1;
            w         <= 1'b1;
          end
        end
        WR: begin
          state     <= IDLE;
          sel       <= 1'b0;
          w         <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          k         <= '0;
        end
        // sel covers RD_LAT cycles; the following cycle captures the core output.
        RD_REQ: if (capture) begin
          state      <= SEND;
          dout_valid <= 1'b1;
        end else begin
          lat <= lat + LW'(1);
          if (lat == LW'(RD_LAT - 1)) sel <= 1'b0;
        end
        SEND: if (dout_hs) begin
          if (last) begin
            state      <= IDLE;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
            k          <= '0;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tiny_host_port.sv
// Directed self-checking bench for tiny_host_port with a 1-cycle behavioural core RAM.
module tb_tiny_host_port;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [5:0]    cmd_addr = '0;
  logic          din_valid = 1'b0, din_ready;
  logic [31:0]   din = '0;
  logic          dout_valid, dout_ready = 1'b0;
  logic [31:0]   dout;
  logic          sel, w, busy;
  logic [5:0]    addr;
  logic [1187:0] data;
  logic [1187:0] out = '0;

  logic [1187:0] mem [0:63];
  int            wcount = 0;
  int            checks = 0, passed = 0;
  logic [1215:0] p0, p3, p5, pa, rv;
  int            n, viol, d, w0, bad;
  bit            tmo;

  tiny_host_port dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .sel(sel), .addr(addr), .w(w), .data(data), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sel) begin
    if (w) mem[addr] <= data;
    else   out <= mem[addr];
  end

  always @(negedge clk) if (w) wcount++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic int fdiff(input logic [1215:0] a, input logic [1215:0] b);
    for (int i = 0; i < 38; i++) if (a[32*i +: 32] !== b[32*i +: 32]) return i;
    return 0;
  endfunction

  task automatic do_cmd(input logic wr, input logic [5:0] a, output bit to);
    int g;
    g = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
    while (cmd_ready !== 1'b1 && g < 200) begin @(negedge clk); g++; end
    to = (cmd_ready !== 1'b1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_chunks(input logic [1215:0] pv, input int cnt, output bit to);
    int g;
    to = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      g = 0;
      din = pv[32*i +: 32]; din_valid = 1'b1;
      while (din_ready !== 1'b1 && g < 200) begin @(negedge clk); g++; end
      if (din_ready !== 1'b1) to = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    din_valid = 1'b0;
  endtask

  task automatic recv_chunks(input bit stall, output logic [1215:0] pv, output int cnt,
                             output int v, output bit to);
    logic [31:0] prev;
    bit stalled;
    int g;
    pv = '0; cnt = 0; v = 0; stalled = 1'b0; g = 0; prev = '0;
    while (cnt < 38 && g < 1000) begin
      dout_ready = stall ? g[0] : 1'b1;
      if (stalled && (dout !== prev || dout_valid !== 1'b1)) v++;
      if (dout_valid === 1'b1 && dout_ready) begin pv[32*cnt +: 32] = dout; cnt++; end
      stalled = (dout_valid === 1'b1) && !dout_ready;
      prev = dout;
      @(posedge clk); @(negedge clk); g++;
    end
    dout_ready = 1'b0;
    to = (cnt < 38);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++; if ({cmd_ready, busy, sel, w, din_ready, dout_valid} !== 6'b100000)
      $display("FAIL reset_ctrl: got %b want 100000", {cmd_ready, busy, sel, w, din_ready, dout_valid});
    else passed++;
    checks++; if (addr !== 6'd0) $display("FAIL reset_addr: got %h want 00", addr); else passed++;
    checks++; if (data !== '0) $display("FAIL reset_data: got nonzero want 0"); else passed++;
    checks++; if (dout !== 32'd0) $display("FAIL reset_dout: got %h want 0", dout); else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_addr0();
    w0 = wcount;
    do_cmd(1'b1, 6'd0, tmo);
    checks++; if ({tmo, cmd_ready, busy, din_ready} !== 4'b0011)
      $display("FAIL wr0_load: got %b want 0011", {tmo, cmd_ready, busy, din_ready}); else passed++;
    send_chunks(p0, 38, tmo);
    checks++; if ({tmo, sel, w, addr} !== {3'b011, 6'd0})
      $display("FAIL wr0_strobe: got %b want 011000000", {tmo, sel, w, addr}); else passed++;
    checks++; if (data !== p0[1187:0]) begin
      d = fdiff(1216'(data), p0);
      $display("FAIL wr0_data: chunk %0d got %h want %h", d, data[32*d +: 32], p0[32*d +: 32]);
    end else passed++;
    @(negedge clk);
    checks++; if ({busy, sel, w, cmd_ready} !== 4'b0001)
      $display("FAIL wr0_release: got %b want 0001", {busy, sel, w, cmd_ready}); else passed++;
    checks++; if (wcount - w0 !== 1) $display("FAIL wr0_wcount: got %0d want 1", wcount - w0); else passed++;
  endtask

  task automatic test_read_back();
    do_cmd(1'b1, 6'd3, tmo);
    send_chunks(p3, 38, tmo);
    checks++; if (tmo || data !== p3[1187:0] || addr !== 6'd3)
      $display("FAIL wr3_data: got addr %h want 03 (data match %0d)", addr, data === p3[1187:0]);
    else passed++;
    @(negedge clk);
    w0 = wcount;
    do_cmd(1'b0, 6'd0, tmo);
    recv_chunks(1'b0, rv, n, viol, tmo);
    checks++; if (tmo || n !== 38) $display("FAIL rd0_count: got %0d want 38", n); else passed++;
    checks++; if (rv[31:0] !== 32'h20504191) $display("FAIL rd0_chunk0: got %h want 20504191", rv[31:0]);
    else passed++;
    checks++; if (rv !== p0) begin
      d = fdiff(rv, p0);
      $display("FAIL rd0_value: chunk %0d got %h want %h", d, rv[32*d +: 32], p0[32*d +: 32]);
    end else passed++;
    do_cmd(1'b0, 6'd3, tmo);
    recv_chunks(1'b0, rv, n, viol, tmo);
    checks++; if (rv !== p3) begin
      d = fdiff(rv, p3);
      $display("FAIL rd3_value: chunk %0d got %h want %h", d, rv[32*d +: 32], p3[32*d +: 32]);
    end else passed++;
    checks++; if ({dout_valid, busy, cmd_ready, sel, w} !== 5'b00100)
      $display("FAIL rd_idle: got %b want 00100", {dout_valid, busy, cmd_ready, sel, w}); else passed++;
    checks++; if (wcount !== w0) $display("FAIL rd_no_write: got %0d want %0d", wcount, w0); else passed++;
    checks++; if (data !== p3[1187:0]) $display("FAIL rd_data_held: got mismatch want data unchanged");
    else passed++;
  endtask

  task automatic test_stall_read();
    do_cmd(1'b0, 6'd3, tmo);
    recv_chunks(1'b1, rv, n, viol, tmo);
    checks++; if (viol !== 0) $display("FAIL stall_stable: got %0d violations want 0", viol); else passed++;
    checks++; if (tmo || n !== 38) $display("FAIL stall_count: got %0d want 38", n); else passed++;
    checks++; if (rv !== p3) begin
      d = fdiff(rv, p3);
      $display("FAIL stall_value: chunk %0d got %h want %h", d, rv[32*d +: 32], p3[32*d +: 32]);
    end else passed++;
    checks++; if (dout_valid !== 1'b0) $display("FAIL stall_end: got %b want 0", dout_valid); else passed++;
  endtask

  task automatic test_last_chunk();
    do_cmd(1'b1, 6'd5, tmo);
    send_chunks(p5, 38, tmo);
    checks++; if (tmo || w !== 1'b1 || data[1187:1184] !== 4'h5)
      $display("FAIL last_wr_top: got %h want 5", data[1187:1184]); else passed++;
    checks++; if (data[1183:0] !== p5[1183:0]) $display("FAIL last_wr_low: got mismatch want chunks 0..36 intact");
    else passed++;
    @(negedge clk);
    do_cmd(1'b0, 6'd5, tmo);
    recv_chunks(1'b0, rv, n, viol, tmo);
    checks++; if (rv[1215:1184] !== 32'h00000005)
      $display("FAIL last_rd_chunk37: got %h want 00000005", rv[1215:1184]); else passed++;
    checks++; if (rv[1183:0] !== p5[1183:0]) $display("FAIL last_rd_low: got mismatch want chunks 0..36 intact");
    else passed++;
  endtask

  task automatic test_reset_abort();
    w0 = wcount;
    do_cmd(1'b1, 6'd3, tmo);
    send_chunks(pa, 10, tmo);
    checks++; if ({busy, din_ready} !== 2'b11) $display("FAIL abort_midload: got %b want 11", {busy, din_ready});
    else passed++;
    reset = 1'b0;
    #1;
    checks++; if ({cmd_ready, busy, sel, w, din_ready, dout_valid} !== 6'b100000)
      $display("FAIL abort_ctrl: got %b want 100000", {cmd_ready, busy, sel, w, din_ready, dout_valid});
    else passed++;
    checks++; if (addr !== 6'd0 || data !== '0 || dout !== 32'd0)
      $display("FAIL abort_regs: got addr %h dout %h want 00 00000000", addr, dout); else passed++;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (wcount !== w0) $display("FAIL abort_no_w: got %0d want %0d", wcount, w0); else passed++;
    do_cmd(1'b1, 6'd3, tmo);
    send_chunks(pa, 38, tmo);
    checks++; if (tmo || {sel, w, addr} !== {2'b11, 6'd3} || data !== pa[1187:0])
      $display("FAIL abort_rewrite: got sel/w/addr %b want 11000011", {sel, w, addr}); else passed++;
    @(negedge clk);
    do_cmd(1'b0, 6'd3, tmo);
    recv_chunks(1'b0, rv, n, viol, tmo);
    checks++; if (rv !== pa) begin
      d = fdiff(rv, pa);
      $display("FAIL abort_readback: chunk %0d got %h want %h", d, rv[32*d +: 32], pa[32*d +: 32]);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    int g;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd0;
    @(posedge clk); @(negedge clk);
    checks++; if ({busy, sel, addr} !== {2'b11, 6'd0}) $display("FAIL b2b_first: got %b want 11000000", {busy, sel, addr});
    else passed++;
    cmd_addr = 6'd3;
    rv = '0; n = 0; g = 0; bad = 0; dout_ready = 1'b1;
    while (n < 38 && g < 200) begin
      if (cmd_ready !== 1'b0 || busy !== 1'b1 || addr !== 6'd0) bad++;
      if (dout_valid === 1'b1) begin rv[32*n +: 32] = dout; n++; end
      @(posedge clk); @(negedge clk); g++;
    end
    dout_ready = 1'b0;
    checks++; if (bad !== 0 || n !== 38) $display("FAIL b2b_busy: got %0d bad cycles, %0d chunks want 0, 38", bad, n);
    else passed++;
    checks++; if (rv !== p0) $display("FAIL b2b_value1: got chunk0 %h want %h", rv[31:0], p0[31:0]); else passed++;
    checks++; if ({cmd_ready, busy, addr} !== {2'b10, 6'd0})
      $display("FAIL b2b_idle: got %b want 10000000", {cmd_ready, busy, addr}); else passed++;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if ({busy, sel, addr} !== {2'b11, 6'd3}) $display("FAIL b2b_second: got %b want 11000011", {busy, sel, addr});
    else passed++;
    recv_chunks(1'b0, rv, n, viol, tmo);
    checks++; if (tmo || rv !== pa) $display("FAIL b2b_value2: got chunk0 %h want %h", rv[31:0], pa[31:0]); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    p0 = 1216'(198'h115a25886512165251569195908560596a6695612620504191);
    p3 = 1216'(198'h1559546442405a181195655549614540592955a15a26984015);
    p5 = p3 ^ (p0 << 600);
    p5[1215:1184] = 32'hFFFFFFF5;
    pa = p0 ^ (p3 << 400);
    test_reset();
    test_write_addr0();
    test_read_back();
    test_stall_read();
    p5[1215:1188] = '0;
    test_last_chunk();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
